// File: rtl/ibex_prefetch_req.sv
// Instruction fetch request issuer: drives the req/gnt/rvalid bus and tracks outstanding requests.
// Responses from a stream killed by a branch are dropped before they reach the fetch FIFO.
module ibex_prefetch_req #(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                branch_i,
  input  logic [31:0]         branch_addr_i,
  output logic                busy_o,
  output logic                fifo_clear_o,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                fifo_valid_o,
  output logic [31:0]         fifo_addr_o,
  output logic [31:0]         fifo_rdata_o,
  output logic                fifo_err_o,
  output logic                instr_req_o,
  input  logic                instr_gnt_i,
  output logic [31:0]         instr_addr_o,
  input  logic                instr_rvalid_i,
  input  logic [31:0]         instr_rdata_i,
  input  logic                instr_err_i
);

  function automatic logic [31:0] popcnt(input logic [NUM_REQS-1:0] v);
    logic [31:0] c;
    c = 32'd0;
    for (int i = 0; i < NUM_REQS; i++) begin
      c = c + {31'd0, v[i]};
    end
    return c;
  endfunction

  logic                pending_r;
  logic [31:0]         stored_addr_r;
  logic                branch_rec_r;
  logic [31:0]         fetch_addr_r;
  logic [NUM_REQS-1:0] out_r;
  logic [NUM_REQS-1:0] disc_r;

  logic [31:0]         out_cnt_s;
  logic [31:0]         busy_cnt_s;
  logic                issue_ok_s;
  logic [31:0]         branch_target_s;
  logic                granted_s;
  logic                kill_s;
  logic                pend_next_s;
  logic [31:0]         fetch_next_s;
  logic [NUM_REQS-1:0] out_next_s;
  logic [NUM_REQS-1:0] disc_next_s;
  logic                found_s;

  // Issue decision, bus address, FIFO side outputs.
  always_comb begin
    out_cnt_s       = popcnt(out_r);
    busy_cnt_s      = branch_i ? 32'd0 : popcnt(fifo_busy_i);
    issue_ok_s      = req_i & ((out_cnt_s + busy_cnt_s) < NUM_REQS);
    branch_target_s = {branch_addr_i[31:2], 2'b00};
    instr_req_o     = ~rst_i & (pending_r | issue_ok_s);
    if (pending_r) begin
      instr_addr_o = stored_addr_r;
    end else if (branch_i) begin
      instr_addr_o = branch_target_s;
    end else begin
      instr_addr_o = {fetch_addr_r[31:2], 2'b00};
    end
    granted_s    = instr_req_o & instr_gnt_i;
    // A pending request that saw a branch belongs to the killed stream.
    kill_s       = pending_r & (branch_rec_r | branch_i);
    pend_next_s  = instr_req_o & ~instr_gnt_i;
    fifo_clear_o = branch_i;
    fifo_addr_o  = branch_addr_i;
    fifo_valid_o = instr_rvalid_i & out_r[0] & ~disc_r[0] & ~branch_i;
    fifo_rdata_o = instr_rdata_i;
    fifo_err_o   = instr_err_i;
    busy_o       = instr_req_o | (|out_r);
  end

  // Next fetch address: branch target wins over sequential increment for a killed grant.
  always_comb begin
    fetch_next_s = fetch_addr_r;
    if (branch_i & pending_r) begin
      fetch_next_s = branch_target_s;
    end else if (granted_s & ~kill_s) begin
      fetch_next_s = instr_addr_o + 32'd4;
    end else if (branch_i) begin
      fetch_next_s = branch_target_s;
    end else begin
      fetch_next_s = fetch_addr_r;
    end
  end

  // Slot queue update: mark discards, shift on response, then allocate on grant.
  always_comb begin
    out_next_s  = out_r;
    disc_next_s = branch_i ? (disc_r | out_r) : disc_r;
    found_s     = 1'b0;
    if (instr_rvalid_i & out_r[0]) begin
      out_next_s  = out_next_s >> 32'd1;
      disc_next_s = disc_next_s >> 32'd1;
    end else begin
      out_next_s  = out_next_s;
    end
    for (int i = 0; i < NUM_REQS; i++) begin
      if (granted_s & ~found_s & ~out_next_s[i]) begin
        out_next_s[i]  = 1'b1;
        disc_next_s[i] = kill_s;
        found_s        = 1'b1;
      end else begin
        found_s        = found_s;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_r     <= 1'b0;
      stored_addr_r <= 32'd0;
      branch_rec_r  <= 1'b0;
      fetch_addr_r  <= 32'd0;
      out_r         <= {NUM_REQS{1'b0}};
      disc_r        <= {NUM_REQS{1'b0}};
    end else begin
      pending_r     <= pend_next_s;
      stored_addr_r <= instr_addr_o;
      branch_rec_r  <= pend_next_s & kill_s;
      fetch_addr_r  <= fetch_next_s;
      out_r         <= out_next_s;
      disc_r        <= disc_next_s;
    end
  end

endmodule
